sha256_pad: RTL and testbench
=============================

// Module: sha256_pad
// PURPOSE
//  Upstream feeder for the sha256 core: turns a byte stream into padded 512-bit blocks.
//  Packs bytes into 32-bit words and appends the 0x80 marker, zero fill and 64-bit bit length.
//  Output is the core's in_* word stream, including in_last on the final block's last word.
//  Output words are little-endian packed (first byte in [7:0]); the core byte-swaps on input.
// PARAMETERS
//  CNT_WIDTH  32  message byte counter width; bit length = {cnt,3'b0}, upper length bits 0, cnt wraps mod 2^CNT_WIDTH
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   reset, synchronous, active-high
//  in_data_i    in   8   message byte
//  in_last_i    in   1   final byte of message (messages are >= 1 byte)
//  in_valid_i   in   1   byte valid
//  in_ready_o   out  1   byte accepted when in_valid_i & in_ready_o
//  out_data_o   out  32  word to core (byte k of word in [8k+7:8k])
//  out_last_o   out  1   word 15 of final block of message
//  out_valid_o  out  1   word valid
//  out_ready_i  in   1   word consumed when out_valid_o & out_ready_i
// BEHAVIOUR
//  Clocking: one clock clk_i; reset rst_i is synchronous and active-high.
//  Reset: out_valid_o=0, out_last_o=0, out_data_o=0, byte_idx=0, word_idx=0, cnt=0, state=MSG.
//  in_ready_o = 1 in the first cycle after reset release.
//  State: word_idx 0..15 (word in block), byte_idx 0..3 (byte in word), assembly reg asm.
//  Output register holds out_data_o/out_last_o stable while out_valid_o & !out_ready_i.
//  Output register loads only when empty or being consumed in the same cycle.
//  FSM MSG:
//   - in_ready_o = (state==MSG) & (byte_idx!=3 | !out_valid_o | out_ready_i); combinational.
//   - Each accepted byte is written to asm[byte_idx]; cnt+1; byte_idx+1.
//   - On an accepted byte with byte_idx==3, or with in_last_i: word -> output reg next cycle.
//   - A word leaving MSG advances word_idx (15 wraps to 0).
//   - Accepted byte with in_last_i, byte_idx<3: 0x80 at byte_idx+1, zeros above; word emitted; goto FILL.
//   - Accepted byte with in_last_i, byte_idx==3: word emitted unchanged; goto MARK.
//  FSM MARK: emit 32'h0000_0080; goto FILL.
//  FSM FILL:
//   - Emit 32'h0 words until the next word_idx to emit is 14, then goto LENH.
//   - If 0x80 landed in word 14/15, complete the block with zeros first.
//   - Then emit words 0..13 zero in a second block before LENH.
//  FSM LENH: emit word 14 = byte-reversed L[63:32]; goto LENL.
//  FSM LENL: emit word 15 = byte-reversed L[31:0] with out_last_o=1.
//   - Then clear cnt/word_idx/byte_idx; goto MSG.
//  L = {cnt,3'b0} zero-extended to 64.
//  Byte-reversed means out_data_o[7:0] = L[63:56] (LENH) or L[31:24] (LENL).
//  Throughput and latency:
//   - Padding states issue one word per cycle when out_ready_i=1.
//   - Message words: latency 1 cycle from completing byte to out_valid_o.
//  Boundaries and backpressure:
//   - in_ready_o=0 outside MSG.
//   - No word is dropped or duplicated under any out_ready_i pattern.
//   - out_last_o is 0 on every word except LENL.
//   - Reset mid-message discards the partial block; out_valid_o falls the next cycle.
// TESTING
//  "abc" (61,62,63 last) -> 16 words:
//   - word0=0x80636261; words1..14=0; word15=0x18000000; out_last_o only on word15.
//  55 bytes 0x00 -> 16 words:
//   - word13=0x80000000; word15=0xB8010000 (L=440).
//  56 bytes 0x00 -> 32 words:
//   - word14=0x00000080; words15..30=0; word31=0xC0010000; out_last_o only on word31.
//  64 bytes 0x00 -> 32 words:
//   - word16=0x00000080 via MARK; word31=0x00020000 (L=512).
//  "abc" with random out_ready_i (30% duty) and random in_valid_i:
//   - identical 16-word sequence; out_data_o stable while stalled.
//   - Feeding sha256 yields digest 0xba7816bf...f20015ad.
//  rst_i pulse after 20 bytes of a message, then "abc":
//   - output is exactly the "abc" sequence above; no stale words.

Source files
------------

// File: rtl/sha256_pad_if.sv
// Byte-in / word-out handshake bundle between a message source, the padder
// and the sha256 core word input.
interface sha256_pad_if;
    logic [7:0]  in_data_i;
    logic        in_last_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    // padder side
    modport slave (
        input  in_data_i, in_last_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_last_o, out_valid_o
    );

    // source/sink side (byte producer and core consumer)
    modport master (
        output in_data_i, in_last_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_last_o, out_valid_o
    );
endinterface

// File: rtl/sha256_pad.sv
// sha256_pad: packs a byte stream into little-endian 32-bit words and appends
// the SHA-256 padding (0x80 marker, zero fill, 64-bit bit length) so the core
// sees complete 512-bit blocks, with out_last_o on the final block's word 15.
module sha256_pad #(
    parameter int CNT_WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sha256_pad_if.slave  bus
);
    typedef enum logic [2:0] {S_MSG, S_MARK, S_FILL, S_LENH, S_LENL} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_byte_idx;
    logic [3:0]           r_word_idx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_asm;
    logic                 r_pend;     // padded final word parked in r_asm, output was busy
    logic [31:0]          r_out_data;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_acc;
    logic        w_load;
    logic [31:0] w_ld_data;
    logic        w_ld_last;
    logic        w_word_adv;
    logic        w_pend_set;
    logic        w_pend_clr;
    logic        w_clear;
    logic [31:0] w_word;
    logic [63:0] w_len;

    assign w_out_free     = !r_out_valid || bus.out_ready_i;
    assign w_len          = 64'(r_cnt) << 3;
    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_last_o  = r_out_last;
    assign bus.out_valid_o = r_out_valid;

    // Current word with the incoming byte merged; on a final byte the marker
    // and zero fill go into the bytes above it so the word is complete.
    always_comb begin
        w_word = r_asm;
        for (int k = 0; k < 4; k++) begin
            if (k == int'(r_byte_idx))
                w_word[8*k +: 8] = bus.in_data_i;
            else if (bus.in_last_i && k == int'(r_byte_idx) + 1)
                w_word[8*k +: 8] = 8'h80;
            else if (bus.in_last_i && k > int'(r_byte_idx))
                w_word[8*k +: 8] = 8'h00;
        end
    end

    // Next-state and word-issue decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_acc       = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = 32'h0;
        w_ld_last   = 1'b0;
        w_word_adv  = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        w_clear     = 1'b0;
        if (r_state == S_MSG) begin
            // a byte completing a word needs room in the output register
            w_in_ready = (r_byte_idx != 2'd3) || w_out_free;
            w_acc      = w_in_ready && bus.in_valid_i;
            if (w_acc && (r_byte_idx == 2'd3 || bus.in_last_i)) begin
                w_word_adv = 1'b1;
                if (w_out_free) begin
                    w_load    = 1'b1;
                    w_ld_data = w_word;
                end else begin
                    w_pend_set = 1'b1;
                end
                if (bus.in_last_i) begin
                    if (r_byte_idx == 2'd3)       w_state_nxt = S_MARK;
                    else if (r_word_idx == 4'd13) w_state_nxt = S_LENH;
                    else                          w_state_nxt = S_FILL;
                end
            end
        end else if (w_out_free) begin
            if (r_pend) begin
                // parked final message word goes first; its index was already counted
                w_load     = 1'b1;
                w_ld_data  = r_asm;
                w_pend_clr = 1'b1;
            end else begin
                w_load     = 1'b1;
                w_word_adv = 1'b1;
                case (r_state)
                    S_MARK: begin
                        w_ld_data   = 32'h0000_0080;
                        w_state_nxt = (r_word_idx == 4'd13) ? S_LENH : S_FILL;
                    end
                    S_FILL: begin
                        w_ld_data   = 32'h0;
                        w_state_nxt = (r_word_idx == 4'd13) ? S_LENH : S_FILL;
                    end
                    S_LENH: begin
                        w_ld_data   = {w_len[39:32], w_len[47:40], w_len[55:48], w_len[63:56]};
                        w_state_nxt = S_LENL;
                    end
                    default: begin
                        w_ld_data   = {w_len[7:0], w_len[15:8], w_len[23:16], w_len[31:24]};
                        w_ld_last   = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = S_MSG;
                    end
                endcase
            end
        end
    end

    // State, counters and byte assembly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_MSG;
            r_byte_idx <= 2'd0;
            r_word_idx <= 4'd0;
            r_cnt      <= '0;
            r_asm      <= 32'h0;
            r_pend     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_asm      <= w_word;
                r_cnt      <= r_cnt + 1'b1;
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_pend_set)      r_pend <= 1'b1;
            else if (w_pend_clr) r_pend <= 1'b0;
            if (w_clear) begin
                r_cnt      <= '0;
                r_byte_idx <= 2'd0;
                r_word_idx <= 4'd0;
            end else if (w_word_adv) begin
                r_word_idx <= r_word_idx + 4'd1;
            end
        end
    end

    // Output register: loads only when empty or drained this cycle, else holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_data  <= 32'h0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_ld_data;
            r_out_last  <= w_ld_last;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sha256_pad.sv
// Directed bench for sha256_pad: table of messages with hand-computed key
// words, a byte-level padding reference for the full word sequence, and
// hand-written reset sequences.
module tb_sha256_pad;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_pad_if bus();
    sha256_pad #(.CNT_WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        int          nbytes;
        int          kind;      // 0 "abc", 1 zeros, 2 bytes 1,2,3,...
        int          rdy_pct;
        int          vld_pct;
        int          nwords;
        int          ia;
        logic [31:0] va;
        int          ib;
        logic [31:0] vb;
    } vec_t;

    vec_t        vecs[7];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  msg_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];
    logic [31:0] ref_q[$];
    logic        done;
    logic        bad_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_msg(input int kind, input int n);
        msg_q = {};
        for (int i = 0; i < n; i++) begin
            if (kind == 0)      msg_q.push_back(8'h61 + 8'(i));
            else if (kind == 1) msg_q.push_back(8'h00);
            else                msg_q.push_back(8'(i + 1));
        end
    endtask

    // Textbook padding on a byte array, then little-endian word packing.
    task automatic build_ref();
        logic [7:0]  p[$];
        logic [63:0] len;
        p   = msg_q;
        len = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        ref_q = {};
        for (int i = 0; i < p.size() / 4; i++)
            ref_q.push_back({p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]});
    endtask

    // Feed msg_q with random valid/ready duty, collect words until out_last.
    task automatic run(input int rdy_pct, input int vld_pct);
        int          bi;
        int          cyc;
        logic        hold;
        logic [31:0] held;
        bi = 0; cyc = 0; hold = 1'b0; held = 32'h0;
        done = 1'b0; bad_rdy = 1'b0;
        got_q = {}; got_last_q = {};
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (bi < msg_q.size()) begin
                bus.in_valid_i = ($urandom_range(99) < 32'(vld_pct));
                bus.in_data_i  = msg_q[bi];
                bus.in_last_i  = (bi == msg_q.size() - 1);
            end else begin
                bus.in_valid_i = 1'b0;
                bus.in_last_i  = 1'b0;
            end
            bus.out_ready_i = ($urandom_range(99) < 32'(rdy_pct));
            #1;
            if (hold) chk("stall_hold", {31'b0, bus.out_valid_o, bus.out_data_o}, {31'b0, 1'b1, held});
            if (bi == msg_q.size() && !(bus.out_valid_o && bus.out_last_o) && bus.in_ready_o)
                bad_rdy = 1'b1;
            if (bus.in_valid_i && bus.in_ready_o) bi++;
            if (bus.out_valid_o && bus.out_ready_i) begin
                got_q.push_back(bus.out_data_o);
                got_last_q.push_back(bus.out_last_o);
                if (bus.out_last_o) done = 1'b1;
                hold = 1'b0;
            end else if (bus.out_valid_o) begin
                hold = 1'b1;
                held = bus.out_data_o;
            end else begin
                hold = 1'b0;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid_i  = 1'b0;
        bus.in_last_i   = 1'b0;
        bus.out_ready_i = 1'b1;
        chk("timeout", {63'b0, done}, 64'd1);
        chk("in_ready_outside_msg", {63'b0, bad_rdy}, 64'd0);
    endtask

    task automatic compare_ref(input string tag);
        build_ref();
        chk({tag, "_count"}, 64'(got_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), {32'b0, got_q[i]}, {32'b0, ref_q[i]});
            chk($sformatf("%s_last%0d", tag, i), {63'b0, got_last_q[i]}, {63'b0, i == ref_q.size() - 1});
        end
    endtask

    initial begin
        vecs[0] = '{3,  0, 100, 100, 16, 0,  32'h80636261, 15, 32'h18000000};
        vecs[1] = '{55, 1, 100, 100, 16, 13, 32'h80000000, 15, 32'hB8010000};
        vecs[2] = '{56, 1, 100, 100, 32, 14, 32'h00000080, 31, 32'hC0010000};
        vecs[3] = '{64, 1, 100, 100, 32, 16, 32'h00000080, 31, 32'h00020000};
        vecs[4] = '{3,  0, 30,  60,  16, 0,  32'h80636261, 15, 32'h18000000};
        vecs[5] = '{7,  2, 50,  70,  16, 1,  32'h80070605, 15, 32'h38000000};
        vecs[6] = '{61, 2, 30,  100, 32, 15, 32'h0000803D, 31, 32'hE8010000};

        bus.in_data_i   = 8'h00;
        bus.in_last_i   = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'b0, bus.out_valid_o}, 64'd0);
        chk("rst_out_last",  {63'b0, bus.out_last_o},  64'd0);
        chk("rst_out_data",  {32'b0, bus.out_data_o},  64'd0);
        chk("rst_in_ready",  {63'b0, bus.in_ready_o},  64'd1);

        for (int v = 0; v < 7; v++) begin
            build_msg(vecs[v].kind, vecs[v].nbytes);
            run(vecs[v].rdy_pct, vecs[v].vld_pct);
            chk($sformatf("v%0d_nwords", v), 64'(got_q.size()), 64'(vecs[v].nwords));
            if (got_q.size() > vecs[v].ib) begin
                chk($sformatf("v%0d_wa", v), {32'b0, got_q[vecs[v].ia]}, {32'b0, vecs[v].va});
                chk($sformatf("v%0d_wb", v), {32'b0, got_q[vecs[v].ib]}, {32'b0, vecs[v].vb});
            end
            compare_ref($sformatf("v%0d", v));
        end

        // Reset after 20 bytes of a message: partial block must vanish.
        begin
            int acc;
            int cyc;
            acc = 0; cyc = 0;
            while (acc < 20 && cyc < 200) begin
                @(negedge clk);
                bus.in_valid_i  = 1'b1;
                bus.in_data_i   = 8'hA5;
                bus.in_last_i   = 1'b0;
                bus.out_ready_i = 1'b1;
                #1;
                if (bus.in_ready_o) acc++;
                cyc++;
            end
            chk("mid_feed", 64'(acc), 64'd20);
        end
        @(negedge clk);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {63'b0, bus.out_valid_o}, 64'd0);
        chk("midrst_in_ready",  {63'b0, bus.in_ready_o},  64'd1);
        bus.out_ready_i = 1'b1;
        build_msg(0, 3);
        run(100, 100);
        chk("midrst_w0",  {32'b0, got_q.size() > 0  ? got_q[0]  : 32'hX}, {32'b0, 32'h80636261});
        chk("midrst_w15", {32'b0, got_q.size() > 15 ? got_q[15] : 32'hX}, {32'b0, 32'h18000000});
        compare_ref("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
